// File: rtl/shift_pkg.sv
// Shared definitions for the serial operand loaders: FSM encodings and default width.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int OPERAND_W = 12;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for start inputs; the history register resets high so a
// level already high at reset release is not mistaken for a new request.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/shift_in_param.sv
// Parametrised serial-to-parallel operand loader: captures W gated serial bits after
// a start edge and publishes the word in a result register that never shows a partial load.
module shift_in_param
  import shift_pkg::*;
#(
  parameter int W         = OPERAND_W,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         x_in,
  input  logic         x_en,
  input  logic         sx,
  output logic [W-1:0] x_parallel,
  output logic         fx,
  output logic         busy
);

  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [W-1:0]   sr_reg, sr_next;
  logic [W-1:0]   xp_reg, xp_next;
  logic [W-1:0]   sr_shift;
  logic           start;

  rise_detect u_start (
    .clk   (clk),
    .reset (reset),
    .d     (sx),
    .rise  (start)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sr_shift = {sr_reg[W-2:0], x_in};
    end else begin : g_lsb_first
      assign sr_shift = {x_in, sr_reg[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      sr_reg    <= '0;
      xp_reg    <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      sr_reg    <= sr_next;
      xp_reg    <= xp_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    sr_next    = sr_reg;
    xp_next    = xp_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = SHIFT;
          count_next = '0;
          sr_next    = '0;
        end
      end
      SHIFT: begin
        // A new start edge aborts the load and discards any bit offered alongside it.
        if (start) begin
          count_next = '0;
          sr_next    = '0;
        end else if (x_en) begin
          sr_next = sr_shift;
          if (count_reg == LAST) begin
            xp_next    = sr_shift;
            state_next = DONE;
            count_next = '0;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        sr_next    = '0;
      end
    endcase
  end

  assign x_parallel = xp_reg;
  assign fx         = (state_reg == DONE);
  assign busy       = (state_reg == SHIFT);

endmodule

// File: doc/shift_in_param.md
Name: shift_in_param

Overview:
- Parametrised serial-to-parallel operand loader; successor to the fixed 12-bit operand loader in the multiplier datapath.
- Captures W serial bits after a rising edge on start input sx and raises done flag fx.
- Generalised over width and bit order; adds a bit-enable for gapped serial streams, restart on a new start, and a result register that holds its value while a load is in progress.
- Sits between the serial operand source and the multiplier core; one instance per operand.

Parameters:
W, 12, operand width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in x_parallel[W-1]; 0 = first received bit lands in x_parallel[0].
CW, $clog2(W), bit counter width; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
x_in  input  1  serial data bit.
x_en  input  1  bit-valid strobe; x_in is sampled only when x_en=1.
sx  input  1  start request; a 0->1 transition starts a load.
x_parallel  output  W  last completed operand; registered.
fx  output  1  load complete; level signal.
busy  output  1  high while a load is in progress.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, count=0, shift register=0, x_parallel=0, fx=0, busy=0, sx_q=1.
  - sx_q resets to 1 so that sx held high across reset release does not start a load; sx must go low first.
- Start edge: start = sx & ~sx_q, where sx_q is sx registered every cycle.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - start -> SHIFT, count=0, shift register cleared.
- SHIFT: busy=1, fx=0.
  - On each edge with x_en=1, one bit is shifted in.
  - MSB_FIRST=1: sr <= {sr[W-2:0], x_in}.
  - MSB_FIRST=0: sr <= {x_in, sr[W-1:1]}.
  - count increments by 1 on each sampled bit.
  - On the edge sampling the bit with count==W-1: x_parallel <= completed word, state -> DONE, count -> 0.
  - x_en=0 cycles: no shift, count holds, no timeout.
- DONE: fx=1, busy=0.
  - fx and x_parallel hold indefinitely.
  - start -> SHIFT with count=0; fx falls at that same edge; x_parallel keeps its value until the next completion.
- Timing, with start detected in cycle t and x_en held high:
  - bits are sampled in cycles t+1 .. t+W;
  - fx=1 and the new x_parallel are visible from cycle t+W+1.
  - The x_in value present during the start cycle t is not sampled.
- Start during SHIFT: the load aborts and restarts; count=0, sr cleared, x_parallel unchanged, fx stays 0.
- Start and x_en=1 in the same cycle while in SHIFT: start wins; the bit is discarded.
- Reset mid-operation: immediate return to the reset values above, including x_parallel=0.
- x_parallel changes only at a completion edge or at reset. It never shows a partial word.
- The count never exceeds W-1. There is no wrap-around path.

Decomposition:
- Shared package shift_pkg holds:
  - state encodings: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10; the unused code 2'b11 recovers to IDLE;
  - the default width constant OPERAND_W=12.
- One sub-module, rise_detect (clk, reset, d, rise):
  - holds the sx_q register with reset value 1;
  - reused for other start inputs in the datapath.

Test Plan:
- W=12, MSB_FIRST=1, x_en=1: pulse sx, then stream 1010_0101_1100 -> x_parallel=12'hA5C and fx=1 in cycle t+13; busy=1 in cycles t+1..t+12.
- W=12, MSB_FIRST=0: same bit stream -> x_parallel=12'h3A5.
- W=8, MSB_FIRST=1: stream 8'hC3 with x_en low for 3 random cycles between bits -> x_parallel=8'hC3; fx delayed by exactly 3 cycles versus the gap-free case.
- After load 12'hA5C, start a second load; after 5 bits pulse sx again, then stream 12'h0F0:
  - x_parallel stays 12'hA5C until the final bit;
  - then x_parallel=12'h0F0 and fx=1.
- Hold sx=1 through reset release -> no load; fx=0, busy=0. Drop sx, raise sx -> load starts.
- Assert reset at bit 7 of a load with x_parallel=12'hA5C -> x_parallel=0, fx=0, busy=0 immediately (asynchronously); the next start completes a normal load.
